cnn_layer_seq: RTL

CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

---
 rtl/cnn_layer_seq_if.sv | 22 ++
 rtl/cnn_layer_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_seq_if.sv
// Host control handshake between the network controller and the layer sequencer:
// run control in one direction, progress and status in the other.
interface cnn_layer_seq_if;
  logic       start;
  logic       abort;
  logic       step_mode;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] return_ctrl;
  logic [3:0] cur_layer;

  modport master (
    output start, abort, step_mode,
    input  busy, done, error, return_ctrl, cur_layer
  );

  modport slave (
    input  start, abort, step_mode,
    output busy, done, error, return_ctrl, cur_layer
  );
endinterface

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: walks NUM_LAYERS layers, releasing the memory-port engines each
// layer uses, driving the MAC/pooling mode lines and reporting progress to the host.
module cnn_layer_seq #(
  parameter int NUM_LAYERS = 5,
  parameter int NUM_MEMS   = 12,
  parameter int TMO_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  cnn_layer_seq_if.slave                 host,
  input  logic [NUM_LAYERS*NUM_MEMS-1:0] layer_mem_mask,
  input  logic [NUM_LAYERS*2-1:0]        layer_mac_mode,
  input  logic [NUM_LAYERS-1:0]          layer_is_pool,
  input  logic [TMO_W-1:0]               tmo_limit,
  input  logic [NUM_MEMS-1:0]            mem_done,
  output logic [NUM_MEMS-1:0]            mem_reset,
  output logic [NUM_LAYERS-1:0]          layer_onehot,
  output logic [1:0]                     MAC_layer,
  output logic                           MAC_enable,
  output logic                           rMAC,
  output logic                           pooling_layer
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    FLUSH,
    PAUSE,
    FIN,
    ERR
  } state_t;

  localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [3:0]              cur_q;
  logic [3:0]              cur_nx;
  logic [7:0]              ret_q;
  logic [7:0]              ret_nx;
  logic                    err_q;
  logic                    err_nx;
  logic                    busy_q;
  logic                    busy_nx;
  logic                    done_q;
  logic                    done_nx;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [TMO_W-1:0]        tmo_nx;
  logic [TMO_W-1:0]        tmo_inc;
  logic                    tmo_hit;
  logic                    all_done;
  logic [NUM_MEMS-1:0]     mask_q;
  logic [NUM_MEMS-1:0]     mask_nx;
  logic [1:0]              mode_nx;
  logic                    pool_nx;
  logic [NUM_LAYERS-1:0]   onehot_nx;
  logic [NUM_MEMS-1:0]     mem_reset_nx;
  logic                    mac_en_nx;
  logic                    rmac_nx;
  logic [NUM_MEMS-1:0]     sel_mask;
  logic [1:0]              sel_mode;
  logic                    sel_pool;
  logic [NUM_LAYERS-1:0]   sel_onehot;

  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.error       = err_q;
  assign host.return_ctrl = ret_q;
  assign host.cur_layer   = cur_q;

  // Pick the configuration slice belonging to the current layer.
  always_comb begin
    sel_mask   = '0;
    sel_mode   = 2'b00;
    sel_pool   = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cur_q == 4'(i)) begin
        sel_mask      = layer_mem_mask[i*NUM_MEMS +: NUM_MEMS];
        sel_mode      = layer_mac_mode[i*2 +: 2];
        sel_pool      = layer_is_pool[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // The first RUN cycle is the one where the counter is still at its SETUP-cleared zero,
  // so engine done levels left over from before the release are never trusted.
  always_comb begin
    all_done = ((mem_done & mask_q) == mask_q);
    tmo_inc  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    tmo_hit  = (tmo_limit != '0) && (tmo_inc >= tmo_limit);

    state_nx  = state;
    cur_nx    = cur_q;
    ret_nx    = ret_q;
    err_nx    = err_q;
    tmo_nx    = tmo_cnt;
    mask_nx   = mask_q;
    mode_nx   = MAC_layer;
    pool_nx   = pooling_layer;
    onehot_nx = layer_onehot;

    if ((state != IDLE) && host.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            state_nx = SETUP;
            cur_nx   = '0;
            ret_nx   = '0;
            err_nx   = 1'b0;
          end
        end
        SETUP: begin
          mask_nx   = sel_mask;
          mode_nx   = sel_pool ? 2'b00 : sel_mode;
          pool_nx   = sel_pool;
          onehot_nx = sel_onehot;
          tmo_nx    = '0;
          state_nx  = RUN;
        end
        RUN: begin
          tmo_nx = tmo_inc;
          if ((tmo_cnt != '0) && all_done) begin
            state_nx = FLUSH;
            ret_nx   = ret_q + 8'd1;
          end else if (tmo_hit) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
        FLUSH: begin
          if (cur_q == LAST_LAYER) begin
            state_nx = FIN;
          end else if (host.step_mode) begin
            state_nx = PAUSE;
          end else begin
            cur_nx   = cur_q + 4'd1;
            state_nx = SETUP;
          end
        end
        PAUSE: begin
          if (host.start) begin
            cur_nx   = cur_q + 4'd1;
            state_nx = SETUP;
          end
        end
        FIN: begin
          state_nx = IDLE;
        end
        ERR: begin
          if (host.start) begin
            state_nx = SETUP;
            cur_nx   = '0;
            ret_nx   = '0;
            err_nx   = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    if (state_nx == IDLE) begin
      mode_nx   = 2'b00;
      pool_nx   = 1'b0;
      onehot_nx = '0;
    end
  end

  // Outputs are decoded from the state being entered so every output is a flop.
  always_comb begin
    mem_reset_nx = '1;
    mac_en_nx    = 1'b0;
    rmac_nx      = 1'b1;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;
    case (state_nx)
      IDLE: busy_nx = 1'b0;
      RUN: begin
        mem_reset_nx = ~mask_nx;
        if (!pool_nx) begin
          mac_en_nx = 1'b1;
          rmac_nx   = 1'b0;
        end
      end
      FIN: done_nx = 1'b1;
      ERR: busy_nx = 1'b0;
      default: ;
    endcase
  end

  // State, progress counters, latched layer configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_q         <= '0;
      ret_q         <= '0;
      err_q         <= 1'b0;
      tmo_cnt       <= '0;
      mask_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_reset     <= '1;
      MAC_enable    <= 1'b0;
      rMAC          <= 1'b1;
      MAC_layer     <= 2'b00;
      pooling_layer <= 1'b0;
      layer_onehot  <= '0;
    end else begin
      state         <= state_nx;
      cur_q         <= cur_nx;
      ret_q         <= ret_nx;
      err_q         <= err_nx;
      tmo_cnt       <= tmo_nx;
      mask_q        <= mask_nx;
      busy_q        <= busy_nx;
      done_q        <= done_nx;
      mem_reset     <= mem_reset_nx;
      MAC_enable    <= mac_en_nx;
      rMAC          <= rmac_nx;
      MAC_layer     <= mode_nx;
      pooling_layer <= pool_nx;
      layer_onehot  <= onehot_nx;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(layer_onehot));
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) host.done |=> !host.done);

endmodule
